// File: rtl/cfg_afu_reset_seq_pkg.sv
// Shared definitions for the AFU reset sequencer: state encoding and the
// default hold-shift / quiesce-timeout constants.
package cfg_afu_reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FENCE,
    ST_QUIESCE,
    ST_HOLD,
    ST_RELEASE,
    ST_DONE
  } cfg_rst_state_t;

  localparam int unsigned CFG_DUR_SHIFT_DEFAULT       = 4;
  localparam int unsigned CFG_QUIESCE_TIMEOUT_DEFAULT = 4096;

endpackage

// File: rtl/cfg_afu_reset_seq_timer.sv
// cfg_reset_timer: loadable down-counter with a zero flag.
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_load, i_load_val load the counter (takes priority over decrement)
//   i_dec             decrement by one, saturating at zero
//   o_zero            counter currently equals zero
module cfg_reset_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/cfg_afu_reset_seq.sv
// cfg_afu_reset_seq: fences, quiesces, resets and releases the AFU in
// response to function-level or AFU-control reset requests.
// Ports:
//   clock, reset          sole clock, asynchronous active-high reset
//   func_reset_req        pulse: function-level reset write
//   afu_reset_req         pulse: AFU-control reset write
//   reset_duration        hold length selector, sampled at sequence start
//   afu_quiesced          level: AFU has nothing outstanding
//   timeout_clr           pulse: clears timeout_err
//   afu_fence, afu_reset  registered controls to the AFU
//   func_reset_done       completion pulse for served function requests
//   afu_reset_done        completion pulse for served AFU requests
//   busy                  sequence in progress
//   timeout_err           sticky quiesce timeout flag
module cfg_afu_reset_seq
  import cfg_afu_reset_seq_pkg::*;
#(
  parameter int unsigned DUR_SHIFT       = CFG_DUR_SHIFT_DEFAULT,
  parameter int unsigned QUIESCE_TIMEOUT = CFG_QUIESCE_TIMEOUT_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       func_reset_req,
  input  logic       afu_reset_req,
  input  logic [7:0] reset_duration,
  input  logic       afu_quiesced,
  input  logic       timeout_clr,
  output logic       afu_fence,
  output logic       afu_reset,
  output logic       func_reset_done,
  output logic       afu_reset_done,
  output logic       busy,
  output logic       timeout_err
);

  // Hold counter covers (255+1)<<DUR_SHIFT - 1 without wrapping.
  localparam int unsigned HW = 9 + DUR_SHIFT;
  localparam int unsigned QW = $clog2(QUIESCE_TIMEOUT + 1);

  cfg_rst_state_t r_state, w_state_nxt;

  logic          r_pend_func, r_pend_afu;
  logic          r_serve_func, r_serve_afu;
  logic [7:0]    r_dur;
  logic          r_fence, r_afu_rst, r_func_done, r_afu_done, r_busy, r_timeout;

  logic          w_snap, w_timeout_set;
  logic          w_q_load, w_q_dec, w_q_zero;
  logic          w_h_load, w_h_dec, w_h_zero;
  logic [HW-1:0] w_h_val, w_hold_len, w_hold_load;

  assign w_hold_len  = HW'(r_dur) + HW'(1);
  assign w_hold_load = (w_hold_len << DUR_SHIFT) - HW'(1);

  // Quiesce timer runs QUIESCE_TIMEOUT cycles; the hold timer is reused for
  // the two RELEASE cycles since the two phases never overlap.
  cfg_reset_timer #(.WIDTH(QW)) u_quiesce_timer (
    .i_clk      (clock),
    .i_rst      (reset),
    .i_load     (w_q_load),
    .i_load_val (QW'(QUIESCE_TIMEOUT - 1)),
    .i_dec      (w_q_dec),
    .o_zero     (w_q_zero)
  );

  cfg_reset_timer #(.WIDTH(HW)) u_hold_timer (
    .i_clk      (clock),
    .i_rst      (reset),
    .i_load     (w_h_load),
    .i_load_val (w_h_val),
    .i_dec      (w_h_dec),
    .o_zero     (w_h_zero)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_snap        = 1'b0;
    w_timeout_set = 1'b0;
    w_q_load      = 1'b0;
    w_q_dec       = 1'b0;
    w_h_load      = 1'b0;
    w_h_dec       = 1'b0;
    w_h_val       = w_hold_load;
    unique case (r_state)
      ST_IDLE: begin
        if (r_pend_func || r_pend_afu) begin
          w_state_nxt = ST_FENCE;
          w_snap      = 1'b1;
        end
      end
      ST_FENCE: begin
        w_state_nxt = ST_QUIESCE;
        w_q_load    = 1'b1;
      end
      ST_QUIESCE: begin
        if (afu_quiesced) begin
          w_state_nxt = ST_HOLD;
          w_h_load    = 1'b1;
        end else if (w_q_zero) begin
          w_state_nxt   = ST_HOLD;
          w_h_load      = 1'b1;
          w_timeout_set = 1'b1;
        end else begin
          w_q_dec = 1'b1;
        end
      end
      ST_HOLD: begin
        if (w_h_zero) begin
          w_state_nxt = ST_RELEASE;
          w_h_load    = 1'b1;
          w_h_val     = HW'(1);
        end else begin
          w_h_dec = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (w_h_zero) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_h_dec = 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state
  // they describe while staying registered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_pend_func  <= 1'b0;
      r_pend_afu   <= 1'b0;
      r_serve_func <= 1'b0;
      r_serve_afu  <= 1'b0;
      r_dur        <= '0;
      r_fence      <= 1'b0;
      r_afu_rst    <= 1'b0;
      r_func_done  <= 1'b0;
      r_afu_done   <= 1'b0;
      r_busy       <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pend_func <= (r_pend_func & ~w_snap) | func_reset_req;
      r_pend_afu  <= (r_pend_afu  & ~w_snap) | afu_reset_req;
      if (w_snap) begin
        r_serve_func <= r_pend_func;
        r_serve_afu  <= r_pend_afu;
        r_dur        <= reset_duration;
      end
      r_fence     <= (w_state_nxt inside {ST_FENCE, ST_QUIESCE, ST_HOLD, ST_RELEASE});
      r_afu_rst   <= (w_state_nxt == ST_HOLD);
      r_func_done <= (w_state_nxt == ST_DONE) && r_serve_func;
      r_afu_done  <= (w_state_nxt == ST_DONE) && r_serve_afu;
      r_busy      <= (w_state_nxt != ST_IDLE);
      if (w_timeout_set) begin
        r_timeout <= 1'b1;
      end else if (timeout_clr) begin
        r_timeout <= 1'b0;
      end
    end
  end

  assign afu_fence       = r_fence;
  assign afu_reset       = r_afu_rst;
  assign func_reset_done = r_func_done;
  assign afu_reset_done  = r_afu_done;
  assign busy            = r_busy;
  assign timeout_err     = r_timeout;

endmodule

// File: doc/cfg_afu_reset_seq.md
CFG_AFU_RESET_SEQ -- requirements
Module: cfg_afu_reset_seq

Interface
REQ-001 SHALL have parameter DUR_SHIFT, default 4: reset hold length is (reset_duration+1)<<DUR_SHIFT cycles.
REQ-002 SHALL have parameter QUIESCE_TIMEOUT, default 4096: maximum cycles in QUIESCE before forced progress.
REQ-003 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port func_reset_req  input  1  single-cycle pulse: function-level reset write (OFUNC).
REQ-006 SHALL have port afu_reset_req  input  1  single-cycle pulse: AFU-control reset write (OCTRL00).
REQ-007 SHALL have port reset_duration  input  8  tied to the func1 OCTRL00 reset-duration tieoff; sampled at sequence start.
REQ-008 SHALL have port afu_quiesced  input  1  level: AFU has no outstanding commands or responses.
REQ-009 SHALL have port timeout_clr  input  1  pulse: clears timeout_err.
REQ-010 SHALL have port afu_fence  output  1  blocks new TLX commands to the AFU.
REQ-011 SHALL have port afu_reset  output  1  reset to the AFU.
REQ-012 SHALL have port func_reset_done  output  1  single-cycle completion pulse for func requests.
REQ-013 SHALL have port afu_reset_done  output  1  single-cycle completion pulse for AFU requests.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port timeout_err  output  1  sticky: a quiesce timeout occurred.

Function
REQ-016 SHALL latch each request pulse into a pending bit (pend_func, pend_afu) on the following edge; a pulse while its bit is already set is absorbed.
REQ-017 SHALL implement states IDLE, FENCE, QUIESCE, HOLD, RELEASE, DONE; all outputs are registered.
REQ-018 IDLE -> FENCE when either pending bit is set; in that same edge, snapshot both pending bits into serve_func/serve_afu, clear the snapshotted pending bits, and capture reset_duration.
REQ-019 FENCE lasts exactly 1 cycle, with afu_fence=1, then goes to QUIESCE.
REQ-020 QUIESCE -> HOLD on the first cycle afu_quiesced=1. If QUIESCE_TIMEOUT cycles elapse without it, set timeout_err and go to HOLD anyway.
REQ-021 In HOLD, afu_reset=1 and afu_fence=1 for exactly (captured_duration+1)<<DUR_SHIFT cycles. The counter is wide enough for duration 255 with no wrap.
REQ-022 RELEASE lasts 2 cycles, with afu_reset=0 and afu_fence=1.
REQ-023 DONE lasts 1 cycle: pulse func_reset_done if serve_func and afu_reset_done if serve_afu; afu_fence=0; return to IDLE.
REQ-024 Requests arriving after the FENCE snapshot remain pending and start a new sequence from IDLE after DONE; they SHALL NOT restart or extend the current sequence.
REQ-025 reset_duration changes mid-sequence SHALL NOT affect the current hold length.
REQ-026 timeout_clr SHALL clear timeout_err. If a timeout and timeout_clr occur in the same cycle, set wins.
REQ-027 Minimum request-to-done latency, with afu_quiesced already high and DUR_SHIFT=4, duration=0, is 22 cycles: 1 latch + 1 FENCE + 1 QUIESCE + 16 HOLD + 2 RELEASE + 1 DONE.

Reset
REQ-028 On reset assertion, SHALL asynchronously force state=IDLE, pending/serve bits=0, counters=0, afu_fence=0, afu_reset=0, both done pulses=0, busy=0, timeout_err=0.
REQ-029 Reset asserted mid-sequence SHALL abandon the sequence: no done pulse is produced, and pending requests are lost.

Structure
REQ-030 The state enumeration and the default DUR_SHIFT and QUIESCE_TIMEOUT constants SHALL live in the shared cfg package.
REQ-031 A single sub-module, cfg_reset_timer, is natural: a loadable down-counter with a zero flag, instanced once for the quiesce timeout and once for the hold count.

Verification
REQ-032 func_reset_req pulse, afu_quiesced=1, duration=0 -> afu_reset high for exactly 16 cycles, then func_reset_done pulse 22 cycles after the request, afu_reset_done never asserted.
REQ-033 func_reset_req and afu_reset_req in the same cycle, duration=3 -> one sequence, 64-cycle hold, both done pulses in the same cycle.
REQ-034 afu_reset_req during HOLD of a func sequence -> func_reset_done first, then a second full sequence ending in afu_reset_done.
REQ-035 afu_quiesced=0 held forever -> timeout_err set after 4096 QUIESCE cycles, HOLD still entered and done pulsed; timeout_clr then clears timeout_err.
REQ-036 reset_duration changed from 1 to 200 during HOLD -> hold stays at 32 cycles.
REQ-037 reset asserted during HOLD -> afu_reset/afu_fence drop immediately, no done pulse, busy=0.
